// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner: aligns 16/32-bit RISC-V instructions from a word I-cache through a one-word buffer
module rvc_fetch_aligner #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             proc_reset,
    input  logic             fetch_req,
    input  logic [30:0]      fetch_pc,
    input  logic             fetch_flush,
    output logic             inst_valid,
    output logic [31:0]      inst_data,
    output logic             inst_is_rvc,
    output logic             fetch_stall,
    output logic             icache_ren,
    output logic [29:0]      icache_addr,
    input  logic             icache_stall,
    input  logic [31:0]      icache_rdata,
    output logic [CNT_W-1:0] span_cnt
);
    typedef enum logic [1:0] {IDLE, FILL, SPAN} state_t;
    state_t state, state_nx;
    logic [31:0] buf_word;
    logic [29:0] buf_tag, req_addr, req_addr_nx, w;
    logic [15:0] span_hi, span_hi_nx, lo, hi;
    logic        buf_valid, discard, h, hit, lo_rvc, hi_rvc, done, drop;
    assign w      = fetch_pc[30:1];
    assign h      = fetch_pc[0];
    assign lo     = buf_word[15:0];
    assign hi     = buf_word[31:16];
    assign lo_rvc = lo[1:0] != 2'b11;
    assign hi_rvc = hi[1:0] != 2'b11;
    assign hit    = buf_valid && buf_tag == w;
    assign done   = state != IDLE && !icache_stall;
    assign drop   = discard || fetch_flush;
    always_comb begin
        state_nx    = state;
        req_addr_nx = req_addr;
        span_hi_nx  = span_hi;
        inst_valid  = 1'b0;
        inst_data   = 32'd0;
        inst_is_rvc = 1'b0;
        fetch_stall = 1'b0;
        icache_ren  = 1'b0;
        icache_addr = 30'd0;
        case (state)
            IDLE: if (fetch_req && !fetch_flush) begin
                if (hit && (!h || hi_rvc)) begin
                    inst_valid  = 1'b1;
                    inst_is_rvc = h ? 1'b1 : lo_rvc;
                    inst_data   = h ? {16'd0, hi} : (lo_rvc ? {16'd0, lo} : buf_word);
                end else begin
                    fetch_stall = 1'b1;
                    state_nx    = hit ? SPAN : FILL;
                    req_addr_nx = hit ? w + 30'd1 : w;
                    span_hi_nx  = hit ? hi : span_hi;
                end
            end
            FILL: begin
                icache_ren  = 1'b1;
                icache_addr = req_addr;
                fetch_stall = 1'b1;
                state_nx    = done ? IDLE : FILL;
            end
            SPAN: begin
                icache_ren  = 1'b1;
                icache_addr = req_addr;
                inst_valid  = done && !drop;
                fetch_stall = !(done && !drop);
                inst_data   = done && !drop ? {icache_rdata[15:0], span_hi} : 32'd0;
                state_nx    = done ? IDLE : SPAN;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state     <= IDLE;
            buf_word  <= 32'd0;
            buf_tag   <= 30'd0;
            buf_valid <= 1'b0;
            req_addr  <= 30'd0;
            span_hi   <= 16'd0;
            discard   <= 1'b0;
            span_cnt  <= '0;
        end else begin
            state    <= state_nx;
            req_addr <= req_addr_nx;
            span_hi  <= span_hi_nx;
            discard  <= state != IDLE && !done && drop;
            if (done) begin
                buf_word  <= icache_rdata;
                buf_tag   <= req_addr;
                buf_valid <= 1'b1;
            end
            if (state == SPAN && done && !drop && !(&span_cnt))
                span_cnt <= span_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// tb_rvc_fetch_aligner: directed and random checks against a memory-level reference model
module tb_rvc_fetch_aligner;
    logic        clk = 1'b0, proc_reset = 1'b1, fetch_req = 1'b0, fetch_flush = 1'b0;
    logic [30:0] fetch_pc = 31'd0;
    logic        inst_valid, inst_is_rvc, fetch_stall, icache_ren;
    logic [31:0] inst_data;
    logic [29:0] icache_addr;
    logic        icache_stall = 1'b0;
    logic [31:0] icache_rdata = 32'd0;
    logic [1:0]  span_cnt;
    rvc_fetch_aligner #(.CNT_W(2)) dut (
        .clk(clk), .proc_reset(proc_reset), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .fetch_flush(fetch_flush), .inst_valid(inst_valid), .inst_data(inst_data),
        .inst_is_rvc(inst_is_rvc), .fetch_stall(fetch_stall), .icache_ren(icache_ren),
        .icache_addr(icache_addr), .icache_stall(icache_stall), .icache_rdata(icache_rdata),
        .span_cnt(span_cnt)
    );
    always #5 clk = ~clk;
    int n_cmp = 0, n_err = 0;
    logic [31:0] mem [logic [29:0]];
    logic        m_bv, m_busy, m_span, m_disc, hold;
    logic [29:0] m_bt, m_ra, last_addr;
    int          m_cnt, lat, wait_n;
    bit          rand_lat;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] rd(input logic [29:0] a);
        logic [31:0] x;
        if (!mem.exists(a)) begin
            x = $urandom;
            if ($urandom_range(1) == 1) x[1:0] = 2'b11;
            if ($urandom_range(1) == 1) x[17:16] = 2'b11;
            mem[a] = x;
        end
        return mem[a];
    endfunction
    function automatic logic [15:0] half(input logic [30:0] p);
        logic [31:0] x;
        x = rd(p[30:1]);
        return p[0] ? x[31:16] : x[15:0];
    endfunction
    function automatic logic rvc_at(input logic [30:0] p);
        logic [15:0] x;
        x = half(p);
        return x[1:0] != 2'b11;
    endfunction
    function automatic logic [31:0] instr(input logic [30:0] p);
        if (rvc_at(p)) return {16'd0, half(p)};
        return {half(p + 31'd1), half(p)};
    endfunction
    task automatic cycle(input logic req, input logic [30:0] pc, input logic fl);
        logic        e_valid, e_stall, done, disc;
        logic [31:0] e_data;
        logic [29:0] wa;
        @(posedge clk); #1;
        fetch_req = req; fetch_pc = pc; fetch_flush = fl;
        if (icache_ren) begin
            last_addr = icache_addr;
            if (wait_n < lat) begin
                icache_stall = 1'b1;
                wait_n++;
            end else begin
                icache_stall = 1'b0;
                wait_n = 0;
                if (rand_lat) lat = $urandom_range(3);
            end
            icache_rdata = rd(icache_addr);
        end else begin
            icache_stall = 1'($urandom_range(1));
            icache_rdata = $urandom;
        end
        #1;
        chk("ren", icache_ren, m_busy);
        if (m_busy) chk("addr", icache_addr, m_ra);
        chk("cnt", span_cnt, m_cnt);
        e_valid = 1'b0; e_stall = 1'b0; e_data = 32'd0;
        wa = pc[30:1];
        if (!m_busy) begin
            if (req && !fl) begin
                if (m_bv && m_bt == wa && (!pc[0] || rvc_at(pc))) begin
                    e_valid = 1'b1;
                    e_data  = instr(pc);
                end else begin
                    e_stall = 1'b1;
                    m_span  = m_bv && m_bt == wa;
                    m_ra    = m_span ? wa + 30'd1 : wa;
                    m_busy  = 1'b1;
                    m_disc  = 1'b0;
                end
            end
        end else begin
            done = !icache_stall;
            disc = m_disc || fl;
            if (m_span && done && !disc) begin
                e_valid = 1'b1;
                e_data  = instr(pc);
            end else e_stall = 1'b1;
            if (done) begin
                m_bv = 1'b1; m_bt = m_ra; m_busy = 1'b0; m_disc = 1'b0;
                if (m_span && !disc && m_cnt < 3) m_cnt++;
            end else m_disc = disc;
        end
        chk("valid", inst_valid, e_valid);
        chk("stall", fetch_stall, e_stall);
        if (e_valid) begin
            chk("data", inst_data, e_data);
            chk("rvc", inst_is_rvc, rvc_at(pc));
        end
        hold = e_stall;
    endtask
    task automatic do_reset();
        @(posedge clk); #1;
        proc_reset = 1'b1; fetch_req = 1'b0; fetch_flush = 1'b0;
        @(posedge clk); #1;
        chk("rst_ren", icache_ren, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_stall", fetch_stall, 0);
        chk("rst_addr", icache_addr, 0);
        chk("rst_data", inst_data, 0);
        chk("rst_cnt", span_cnt, 0);
        proc_reset = 1'b0;
        m_bv = 1'b0; m_busy = 1'b0; m_disc = 1'b0; m_span = 1'b0; m_cnt = 0;
        wait_n = 0; hold = 1'b0;
    endtask
    task automatic serve(input logic [30:0] pc, output logic [31:0] d, output int n);
        n = 0;
        do begin
            cycle(1'b1, pc, 1'b0);
            n++;
        end while (!inst_valid && n < 20);
        chk("served", inst_valid, 1);
        d = inst_data;
    endtask
    initial begin
        logic [31:0] d;
        int          n;
        logic [30:0] pc;
        logic        req, fl;
        int          ws;
        rand_lat = 1'b0; lat = 0; wait_n = 0; last_addr = '1;
        m_bt = '0; m_ra = '0;
        repeat (2) @(posedge clk);
        // cold miss
        mem.delete(); mem[0] = 32'h00A00093; lat = 3;
        do_reset();
        serve(31'h0, d, n);
        chk("cold_data", d, 32'h00A00093);
        chk("cold_lat", n, 6);
        chk("cold_rvc", inst_is_rvc, 0);
        // compressed pair
        mem.delete(); mem[0] = 32'h45014581; lat = 1;
        do_reset();
        serve(31'h0, d, n);
        chk("fill_lat", n, 4);
        serve(31'h0, d, n);
        chk("pair0_lat", n, 1);
        chk("pair0_data", d, 32'h00004581);
        chk("pair0_rvc", inst_is_rvc, 1);
        serve(31'h1, d, n);
        chk("pair1_lat", n, 1);
        chk("pair1_data", d, 32'h00004501);
        chk("pair1_ren", icache_ren, 0);
        // span
        mem.delete(); mem[0] = 32'h00931111; mem[1] = 32'hABCD00A0; lat = 1;
        do_reset();
        serve(31'h1, d, n);
        chk("span_data", d, 32'h00A00093);
        chk("span_lat", n, 6);
        chk("span_rvc", inst_is_rvc, 0);
        cycle(1'b0, 31'h1, 1'b0);
        chk("span_cnt", span_cnt, 1);
        serve(31'h3, d, n);
        chk("after_span_lat", n, 1);
        chk("after_span_data", d, 32'h0000ABCD);
        // wrap
        mem.delete(); mem[30'h3FFFFFFF] = 32'h00931111; mem[0] = 32'h000000A0; lat = 0;
        do_reset();
        serve(31'h7FFFFFFF, d, n);
        chk("wrap_data", d, 32'h00A00093);
        chk("wrap_addr", last_addr, 0);
        // flush mid-fill
        mem.delete(); mem[5] = 32'h12345678; lat = 3;
        do_reset();
        cycle(1'b1, 31'd10, 1'b0);
        cycle(1'b1, 31'd10, 1'b1);
        repeat (3) cycle(1'b0, 31'd10, 1'b0);
        serve(31'd10, d, n);
        chk("flush_hit_lat", n, 1);
        chk("flush_hit_data", d, 32'h00005678);
        // reset mid-span
        mem.delete(); mem[20] = 32'h00030001; lat = 0;
        do_reset();
        repeat (3) cycle(1'b1, 31'd41, 1'b0);
        lat = 5;
        cycle(1'b1, 31'd41, 1'b0);
        chk("in_span_ren", icache_ren, 1);
        do_reset();
        // saturation
        mem.delete(); lat = 0;
        for (int k = 30; k <= 35; k++) mem[k] = 32'h00030001;
        for (int k = 30; k <= 34; k++) serve(31'(2 * k + 1), d, n);
        cycle(1'b0, 31'd0, 1'b0);
        chk("sat_cnt", span_cnt, 3);
        // random
        mem.delete(); rand_lat = 1'b1; lat = 2;
        do_reset();
        pc = 31'd0; req = 1'b0; fl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!hold && $urandom_range(499) == 0) do_reset();
            if (!hold) begin
                req = $urandom_range(7) != 0;
                fl  = $urandom_range(15) == 0;
                if ($urandom_range(3) == 0) begin
                    ws = $urandom_range(7);
                    pc = {ws < 6 ? 30'(ws) : 30'h3FFFFFFE + 30'(ws - 6), 1'($urandom_range(1))};
                end else pc = pc + (rvc_at(pc) ? 31'd1 : 31'd2);
            end else begin
                req = 1'b1;
                fl  = $urandom_range(31) == 0;
            end
            cycle(req, pc, fl);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
